// File: rtl/fetch_hazard_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID register.
// It also handles load-use stalls and the bubbles inserted after a redirect.
module fetch_hazard_stage #(
    parameter int          FLUSH_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    output logic [31:0] imem_addr,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus4_out,
    output logic        nop,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH - 1);
    localparam state_t REDIRECT_STATE = (FLUSH_DEPTH > 1) ? FLUSH : FILL;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc4_reg, pc4_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [15:0] stall_reg, stall_next;
    logic [31:0] pc_inc;
    logic        rs_match;
    logic        rt_match;
    logic        hazard;

    assign pc_inc   = pc_reg + 32'd4;
    assign rs_match = (idex_rt == instr_reg[25:21]);
    assign rt_match = (idex_rt == instr_reg[20:16]);
    // Only a real load into a non-zero register can create a load-use dependency.
    assign hazard   = (state_reg == RUN) && idex_memread && (idex_rt != 5'd0)
                      && (rs_match || rt_match);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pc4_next   = pc4_reg;
        cnt_next   = cnt_reg;
        stall_next = stall_reg;

        if (redirect) begin
            pc_next    = redirect_pc;
            instr_next = 32'd0;
            pc4_next   = 32'd0;
            cnt_next   = FLUSH_INIT;
            state_next = REDIRECT_STATE;
        end else begin
            unique case (state_reg)
                FILL: begin
                    instr_next = imem_data;
                    pc4_next   = pc_inc;
                    pc_next    = pc_inc;
                    state_next = RUN;
                end
                RUN: begin
                    if (hazard) begin
                        if (stall_reg != 16'hFFFF) begin
                            stall_next = stall_reg + 16'd1;
                        end
                    end else begin
                        instr_next = imem_data;
                        pc4_next   = pc_inc;
                        pc_next    = pc_inc;
                    end
                end
                FLUSH: begin
                    // The PC keeps moving to account for fetches that are thrown away.
                    pc_next    = pc_inc;
                    instr_next = 32'd0;
                    pc4_next   = 32'd0;
                    cnt_next   = cnt_reg - 2'd1;
                    if (cnt_reg <= 2'd1) begin
                        state_next = FILL;
                    end
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= FILL;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
            pc4_reg   <= 32'd0;
            cnt_reg   <= 2'd0;
            stall_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pc4_reg   <= pc4_next;
            cnt_reg   <= cnt_next;
            stall_reg <= stall_next;
        end
    end

    assign imem_addr       = pc_reg;
    assign instruction_out = instr_reg;
    assign pc_plus4_out    = pc4_reg;
    assign stall_count     = stall_reg;
    assign nop             = (state_reg != RUN) || hazard;

endmodule

// File: tb/tb_fetch_hazard_stage.sv
// Directed bench for fetch_hazard_stage with a combinational address-indexed instruction memory.
module tb_fetch_hazard_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [31:0] imem_addr;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus4_out;
    logic        nop;
    logic [15:0] stall_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_hazard_stage #(.FLUSH_DEPTH(2), .RESET_PC(32'h00000000)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .imem_addr       (imem_addr),
        .instruction_out (instruction_out),
        .pc_plus4_out    (pc_plus4_out),
        .nop             (nop),
        .stall_count     (stall_count)
    );

    always #5 Clk = ~Clk;

    // Word at addr: rs field = addr[6:2], rt field = addr[11:7], low half = addr[15:0].
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {6'b0, a[6:2], a[11:7], a[15:0]};
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        idex_memread = 1'b0;
        idex_rt = 5'd0;
        #2;
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_instr", instruction_out, 32'h0);
        check_eq("rst_pc4",   pc_plus4_out, 32'h0);
        check_eq("rst_nop",   {31'd0, nop}, 32'd1);
        check_eq("rst_stall", {16'd0, stall_count}, 32'd0);

        #10 Reset = 1'b1;
        #1;
        check_eq("c1_nop",  {31'd0, nop}, 32'd1);
        check_eq("c1_addr", imem_addr, 32'h0);
        step();
        check_eq("c2_instr", instruction_out, word_at(32'h0));
        check_eq("c2_pc4",   pc_plus4_out, 32'h4);
        check_eq("c2_nop",   {31'd0, nop}, 32'd0);
        check_eq("c2_addr",  imem_addr, 32'h4);

        // Load into r0 never stalls, even though the word in IF/ID names r0.
        idex_memread = 1'b1;
        idex_rt = 5'd0;
        #1;
        check_eq("r0_nop", {31'd0, nop}, 32'd0);
        step();
        check_eq("r0_addr",  imem_addr, 32'h8);
        check_eq("r0_stall", {16'd0, stall_count}, 32'd0);
        idex_memread = 1'b0;

        for (int i = 0; i < 4; i++) step();
        check_eq("pre_stall_instr", instruction_out, word_at(32'h14));
        check_eq("pre_stall_addr",  imem_addr, 32'h18);

        // word@0x14 has rs=5: load-use stall for one cycle.
        idex_memread = 1'b1;
        idex_rt = 5'd5;
        #1;
        check_eq("lu_nop", {31'd0, nop}, 32'd1);
        step();
        check_eq("lu_addr",  imem_addr, 32'h18);
        check_eq("lu_instr", instruction_out, word_at(32'h14));
        check_eq("lu_pc4",   pc_plus4_out, 32'h18);
        check_eq("lu_stall", {16'd0, stall_count}, 32'd1);
        idex_memread = 1'b0;
        idex_rt = 5'd0;
        #1;
        check_eq("lu_clear_nop", {31'd0, nop}, 32'd0);
        step();
        check_eq("lu_adv_instr", instruction_out, word_at(32'h18));
        check_eq("lu_adv_addr",  imem_addr, 32'h1C);

        step();
        check_eq("pre_redir_addr", imem_addr, 32'h20);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check_eq("rd0_addr",  imem_addr, 32'h100);
        check_eq("rd0_instr", instruction_out, 32'h0);
        check_eq("rd0_nop",   {31'd0, nop}, 32'd1);
        step();
        check_eq("rd1_addr",  imem_addr, 32'h104);
        check_eq("rd1_instr", instruction_out, 32'h0);
        check_eq("rd1_nop",   {31'd0, nop}, 32'd1);
        step();
        check_eq("rd2_instr", instruction_out, word_at(32'h104));
        check_eq("rd2_pc4",   pc_plus4_out, 32'h108);
        check_eq("rd2_nop",   {31'd0, nop}, 32'd0);
        check_eq("rd2_addr",  imem_addr, 32'h108);

        // word@0x104 has rt=2; hazard and redirect together: redirect wins.
        idex_memread = 1'b1;
        idex_rt = 5'd2;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check_eq("both_nop", {31'd0, nop}, 32'd1);
        step();
        redirect = 1'b0;
        idex_memread = 1'b0;
        idex_rt = 5'd0;
        check_eq("both_addr",  imem_addr, 32'h200);
        check_eq("both_instr", instruction_out, 32'h0);
        check_eq("both_stall", {16'd0, stall_count}, 32'd1);

        // Now in FLUSH: asynchronous reset clears everything without a clock edge.
        #2 Reset = 1'b0;
        #1;
        check_eq("arst_addr",  imem_addr, 32'h0);
        check_eq("arst_instr", instruction_out, 32'h0);
        check_eq("arst_pc4",   pc_plus4_out, 32'h0);
        check_eq("arst_stall", {16'd0, stall_count}, 32'd0);
        check_eq("arst_nop",   {31'd0, nop}, 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        step();
        check_eq("restart_instr", instruction_out, word_at(32'h0));
        check_eq("restart_addr",  imem_addr, 32'h4);

        // PC wraps modulo 2^32 through FLUSH and FILL.
        redirect = 1'b1;
        redirect_pc = 32'hFFFFFFF8;
        step();
        redirect = 1'b0;
        step();
        check_eq("wrap_flush_addr", imem_addr, 32'hFFFFFFFC);
        step();
        check_eq("wrap_instr", instruction_out, word_at(32'hFFFFFFFC));
        check_eq("wrap_pc4",   pc_plus4_out, 32'h0);
        check_eq("wrap_addr",  imem_addr, 32'h0);

        // word@0xFFFFFFFC has rs=rt=31: hold the stall past 65535 cycles.
        idex_memread = 1'b1;
        idex_rt = 5'd31;
        for (int i = 0; i < 65534; i++) step();
        check_eq("sat_below", {16'd0, stall_count}, 32'h0000FFFE);
        for (int i = 0; i < 6; i++) step();
        check_eq("sat_stall", {16'd0, stall_count}, 32'h0000FFFF);
        check_eq("sat_addr",  imem_addr, 32'h0);
        idex_memread = 1'b0;
        idex_rt = 5'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
